nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_pkg.sv | 5 +
 rtl/nibble_serial_adder_cla4_slice.sv | 25 ++
 rtl/nibble_serial_adder.sv | 77 +++++++
 tb/tb_nibble_serial_adder.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/nibble_serial_pkg.sv
// nibble_serial_pkg: shared FSM state type and nibble width for the nibble-serial adder
package nibble_serial_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    localparam int NW = 4;
endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// cla4_slice: combinational 4-bit carry-look-ahead adder slice
// ports: a, b (nibble operands), cin (carry in), s (nibble sum), cout (carry out)
module cla4_slice
    import nibble_serial_pkg::*;
(
    input  logic [NW-1:0] a,
    input  logic [NW-1:0] b,
    input  logic          cin,
    output logic [NW-1:0] s,
    output logic          cout
);
    logic [3:0] g, p;
    logic [4:0] c;
    assign g = a & b;
    assign p = a ^ b;
    // every carry is formed directly from generate/propagate terms, no ripple
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign s    = p ^ c[3:0];
    assign cout = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder computed one nibble per cycle through one shared CLA slice
// ports: clk, rst (async, active-high), start/a/b/cin (request, captured in IDLE),
//        busy (in RUN), done (one-cycle result pulse), sum/cout (registered result),
//        ovf (signed overflow, only when NIBBLE_SERIAL_ADDER_OVF_EN is defined)
module nibble_serial_adder
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int NIB = WIDTH / NW;
    localparam int IW  = $clog2(NIB);
    state_t state, state_n;
    logic [IW-1:0] idx;
    logic [WIDTH-1:0] ra, rb;
    logic [NW-1:0] s_a, s_b, s_s;
    logic carry, s_co, last;
    assign last = idx == IW'(NIB - 1);
    assign s_a  = ra[idx*NW +: NW];
    assign s_b  = rb[idx*NW +: NW];
    cla4_slice u_slice (.a(s_a), .b(s_b), .cin(carry), .s(s_s), .cout(s_co));
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;
    always_comb begin
        state_n = state;
        state_n = (state == IDLE) ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
        busy    = state == RUN;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            ra    <= '0;
            rb    <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            done  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                ra    <= a;
                rb    <= b;
                carry <= cin;
                idx   <= '0;
            end else if (state == RUN) begin
                sum[idx*NW +: NW] <= s_s;
                carry             <= s_co;
                idx               <= idx + 1'b1;
                if (last) begin
                    cout <= s_co;
                    done <= 1'b1;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                    // carry into the MSB is recovered as a^b^s of that bit
                    ovf  <= s_a[NW-1] ^ s_b[NW-1] ^ s_s[NW-1] ^ s_co;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: randomized scoreboard bench for nibble_serial_adder
module tb_nibble_serial_adder;
    logic clk = 1'b0, rst, start, cin, busy, done, cout;
    logic [15:0] a, b, sum;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic ovf;
`endif
    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
        int          due;
    } exp_t;
    exp_t q[$];
    int cyc = 0, compared = 0, mismatched = 0;
    logic [15:0] hold_s = '0;
    logic hold_c = 1'b0, hold_v = 1'b0;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        .ovf(ovf),
`endif
        .cout(cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // issued at a negedge while the DUT is idle; returns at the negedge after the accepting edge
    task automatic op(input logic [15:0] x, input logic [15:0] y, input logic c);
        int n = 0;
        logic [16:0] t;
        exp_t e;
        while (busy) begin
            @(negedge clk);
            if (++n > 100) begin
                $display("FAIL op_wait: busy stuck high");
                $fatal(1);
            end
        end
        t = {1'b0, x} + {1'b0, y} + 17'(c);
        e.s = t[15:0];
        e.c = t[16];
        e.v = (x[15] == y[15]) && (t[15] != x[15]);
        e.due = cyc + 5;
        q.push_back(e);
        a = x; b = y; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0 && cyc == q[0].due) begin
            e = q.pop_front();
            chk("done", done, 1);
            chk("sum", sum, e.s);
            chk("cout", cout, e.c);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            chk("ovf", ovf, e.v);
`endif
            hold_s = e.s; hold_c = e.c; hold_v = e.v;
        end else begin
            chk("done_low", done, 0);
            if (q.size() == 0) begin
                chk("hold_sum", sum, hold_s);
                chk("hold_cout", cout, hold_c);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                chk("hold_ovf", ovf, hold_v);
`endif
            end
        end
        chk("busy", busy, q.size() > 0 && cyc < q[0].due);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        op(16'h1234, 16'h4321, 1'b0);
        op(16'hFFFF, 16'h0001, 1'b0);
        op(16'hFFFF, 16'hFFFF, 1'b1);
        op(16'h0008, 16'h0003, 1'b0);
        repeat (2) @(negedge clk);
        op(16'h1234, 16'h4321, 1'b0);
        @(negedge clk);
        start = 1'b1; a = 16'hABCD; b = 16'h1111; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op(16'h5555, 16'hAAAA, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        q.delete();
        hold_s = '0; hold_c = 1'b0; hold_v = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        op(16'h0001, 16'h0001, 1'b0);
        op(16'h7FFF, 16'h0001, 1'b0);
        op(16'h0001, 16'h0001, 1'b0);
        op(16'h8000, 16'h8000, 1'b0);
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        n = 0;
        while (q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) chk("drain", q.size(), 0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
